lv_bist_seq: RTL

LV_BIST_SEQ -- requirements
Module: lv_bist_seq

---
 rtl/lv_bist_pkg.sv | 33 +++
 rtl/lv_bist_seq_if.sv | 27 ++
 rtl/lv_bist_tmo_cnt.sv | 38 +++
 rtl/lv_bist_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lv_bist_pkg.sv
// Shared types and timeout constants for the low-voltage BIST sequencer.
package lv_bist_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StAbist = 2'b01,
    StLbist = 2'b10,
    StDone  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FailNone = 2'b00,
    FailAna  = 2'b01,
    FailLog  = 2'b10,
    FailTmo  = 2'b11
  } fail_code_e;

  localparam int unsigned ClkMDefault       = 48;
  localparam int unsigned AbistTmoUsDefault = 80;
  localparam int unsigned LbistTmoUsDefault = 500;

  function automatic int unsigned tmo_cycles(input int unsigned tmo_us, input int unsigned clk_m);
    return tmo_us * clk_m;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned AbistTmoCyc = tmo_cycles(AbistTmoUsDefault, ClkMDefault);
  localparam int unsigned LbistTmoCyc = tmo_cycles(LbistTmoUsDefault, ClkMDefault);

endpackage

// File: rtl/lv_bist_seq_if.sv
// Handshake bundle between the BIST sequencer, the analog-BIST stage and the logic-BIST engine.
interface lv_bist_seq_if;

  logic       i_bist_req;
  logic       i_bist_abort;
  logic       i_lv_abist_fail;
  logic       i_lbist_en;
  logic       i_lbist_done;
  logic       i_lbist_fail;
  logic       o_bist_en;
  logic       o_lbist_start;
  logic       o_bist_busy;
  logic       o_bist_done;
  logic       o_bist_fail;
  logic [1:0] o_fail_code;

  modport master (
    output i_bist_req, i_bist_abort, i_lv_abist_fail, i_lbist_en, i_lbist_done, i_lbist_fail,
    input  o_bist_en, o_lbist_start, o_bist_busy, o_bist_done, o_bist_fail, o_fail_code
  );

  modport slave (
    input  i_bist_req, i_bist_abort, i_lv_abist_fail, i_lbist_en, i_lbist_done, i_lbist_fail,
    output o_bist_en, o_lbist_start, o_bist_busy, o_bist_done, o_bist_fail, o_fail_code
  );

endinterface

// File: rtl/lv_bist_tmo_cnt.sv
// Phase timeout counter: synchronous clear, count enable, saturating, terminal-count compare.
module lv_bist_tmo_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [Width-1:0] i_limit,
  output logic [Width-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [Width-1:0] CntMax = '1;

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_tc  = (cnt_q == i_limit);

endmodule

// File: rtl/lv_bist_seq.sv
// BIST run sequencer: analog BIST, then logic BIST, each guarded by a timeout; sticky result code.
module lv_bist_seq
  import lv_bist_pkg::*;
#(
  parameter int unsigned CLK_M        = ClkMDefault,
  parameter int unsigned ABIST_TMO_US = AbistTmoUsDefault,
  parameter int unsigned LBIST_TMO_US = LbistTmoUsDefault
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  lv_bist_seq_if.slave  bus
);

  localparam int unsigned AbistCyc = tmo_cycles(ABIST_TMO_US, CLK_M);
  localparam int unsigned LbistCyc = tmo_cycles(LBIST_TMO_US, CLK_M);
  localparam int unsigned CntW     = $clog2(max_u(AbistCyc, LbistCyc) + 1);

  localparam logic [CntW-1:0] AbistLimit = CntW'(AbistCyc - 1);
  localparam logic [CntW-1:0] LbistLimit = CntW'(LbistCyc - 1);

  state_e     state_d, state_q;
  fail_code_e code_d, code_q, end_code;
  logic       req_q, req_rise;
  logic       bist_en_d, bist_en_q;
  logic       lbist_start_d, lbist_start_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;
  logic       fail_d, fail_q;
  logic       end_run, abort_run;
  logic       cnt_clr, cnt_en, cnt_tc;
  logic [CntW-1:0] cnt_limit, cnt_val;

  assign req_rise = bus.i_bist_req & ~req_q;

  always_comb begin
    state_d       = state_q;
    bist_en_d     = bist_en_q;
    lbist_start_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    code_d        = code_q;
    end_run       = 1'b0;
    abort_run     = 1'b0;
    end_code      = FailNone;

    unique case (state_q)
      StIdle: begin
        if (req_rise) begin
          state_d   = StAbist;
          bist_en_d = 1'b1;
          busy_d    = 1'b1;
          code_d    = FailNone;
        end
      end
      StAbist: begin
        if (bus.i_bist_abort) begin
          abort_run = 1'b1;
        end else if (bus.i_lv_abist_fail) begin
          end_run  = 1'b1;
          end_code = FailAna;
        end else if (bus.i_lbist_en) begin
          state_d       = StLbist;
          bist_en_d     = 1'b0;
          lbist_start_d = 1'b1;
        end else if (cnt_tc) begin
          end_run  = 1'b1;
          end_code = FailTmo;
        end
      end
      StLbist: begin
        // A done seen during the start-pulse cycle belongs to a previous run.
        if (bus.i_bist_abort) begin
          abort_run = 1'b1;
        end else if (bus.i_lbist_done && !lbist_start_q) begin
          end_run  = 1'b1;
          end_code = bus.i_lbist_fail ? FailLog : FailNone;
        end else if (cnt_tc) begin
          end_run  = 1'b1;
          end_code = FailTmo;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (end_run) begin
      state_d   = StDone;
      bist_en_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      code_d    = end_code;
    end else if (abort_run) begin
      state_d   = StIdle;
      bist_en_d = 1'b0;
      busy_d    = 1'b0;
      code_d    = FailTmo;
    end

    fail_d = (code_d != FailNone);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      req_q         <= 1'b0;
      bist_en_q     <= 1'b0;
      lbist_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      code_q        <= FailNone;
    end else begin
      state_q       <= state_d;
      req_q         <= bus.i_bist_req;
      bist_en_q     <= bist_en_d;
      lbist_start_q <= lbist_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      code_q        <= code_d;
    end
  end

  // Every state change restarts the count so each phase starts from zero.
  assign cnt_clr   = (state_d != state_q);
  assign cnt_en    = (state_q == StAbist) || (state_q == StLbist);
  assign cnt_limit = (state_q == StLbist) ? LbistLimit : AbistLimit;

  lv_bist_tmo_cnt #(
    .Width (CntW)
  ) u_tmo_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_en    (cnt_en),
    .i_limit (cnt_limit),
    .o_cnt   (cnt_val),
    .o_tc    (cnt_tc)
  );

  assign bus.o_bist_en     = bist_en_q;
  assign bus.o_lbist_start = lbist_start_q;
  assign bus.o_bist_busy   = busy_q;
  assign bus.o_bist_done   = done_q;
  assign bus.o_bist_fail   = fail_q;
  assign bus.o_fail_code   = code_q;

endmodule
